// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM arbiter.
// State encoding, requester IDs and default widths.
package ram_arb_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam logic ID_VID = 1'b0;
    localparam logic ID_CPU = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for video fetch and CPU bus.
// RAM_ARB_RR_EN selects round-robin instead of strict video priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_dout,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_ub,
    input  logic          cpu_lb,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_ub,
    output logic          ram_lb,
    input  logic [DW-1:0] ram_dout
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_ub_q, ram_ub_d;
    logic          ram_lb_q, ram_lb_d;
    logic          vid_ack_q, vid_ack_d;
    logic [DW-1:0] vid_dout_q, vid_dout_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic          pick_cpu;

`ifdef RAM_ARB_RR_EN
    logic          last_q, last_d;

    always_comb begin
        pick_cpu = cpu_req && (!vid_req || last_q == ID_VID);
    end
`else
    always_comb begin
        pick_cpu = cpu_req && !vid_req;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_ub_d   = ram_ub_q;
        ram_lb_d   = ram_lb_q;
        vid_ack_d  = 1'b0;
        vid_dout_d = vid_dout_q;
        cpu_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
`ifdef RAM_ARB_RR_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (vid_req || cpu_req) begin
                    state_d = ACCESS;
                    if (pick_cpu) begin
                        owner_d    = ID_CPU;
                        wr_d       = cpu_we;
                        ram_we_d   = cpu_we;
                        ram_addr_d = cpu_addr;
                        ram_din_d  = cpu_din;
                        ram_ub_d   = cpu_ub;
                        ram_lb_d   = cpu_lb;
                    end else begin
                        owner_d    = ID_VID;
                        wr_d       = 1'b0;
                        ram_we_d   = 1'b0;
                        ram_addr_d = vid_addr;
                        ram_ub_d   = 1'b1;
                        ram_lb_d   = 1'b1;
                    end
`ifdef RAM_ARB_RR_EN
                    last_d = pick_cpu ? ID_CPU : ID_VID;
`endif
                end
            end
            ACCESS: begin
                // Write strobe lasts exactly the one cycle the RAM samples it
                ram_we_d = 1'b0;
                state_d  = DATA;
            end
            DATA: begin
                state_d = IDLE;
                if (owner_q == ID_CPU) begin
                    cpu_ack_d = 1'b1;
                    if (!wr_q) begin
                        cpu_dout_d = ram_dout;
                    end
                end else begin
                    vid_ack_d  = 1'b1;
                    vid_dout_d = ram_dout;
                end
            end
            default: begin
                state_d  = IDLE;
                ram_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= ID_VID;
            wr_q       <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_ub_q   <= 1'b0;
            ram_lb_q   <= 1'b0;
            vid_ack_q  <= 1'b0;
            vid_dout_q <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_ub_q   <= ram_ub_d;
            ram_lb_q   <= ram_lb_d;
            vid_ack_q  <= vid_ack_d;
            vid_dout_q <= vid_dout_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

`ifdef RAM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= ID_VID;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign vid_ack  = vid_ack_q;
    assign vid_dout = vid_dout_q;
    assign cpu_ack  = cpu_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_ub   = ram_ub_q;
    assign ram_lb   = ram_lb_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural byte-laned RAM.
// Define RAM_ARB_RR_EN to check the round-robin build.
module tb_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_dout;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_ub;
    logic          cpu_lb;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_ub;
    logic          ram_lb;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          preload;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ub(cpu_ub), .cpu_lb(cpu_lb),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_ub(ram_ub),
        .ram_lb(ram_lb), .ram_dout(ram_dout)
    );

    // Unwritten words read back as 0x5A00 ^ address
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++)
                mem[i] <= 16'h5A00 ^ 16'(i);
        end else if (ram_we) begin
            if (ram_ub) mem[ram_addr][15:8] <= ram_din[15:8];
            if (ram_lb) mem[ram_addr][7:0] <= ram_din[7:0];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, " vid_ack"}, 32'(vid_ack), 0);
        chk({tag, " cpu_ack"}, 32'(cpu_ack), 0);
        chk({tag, " ram_we"}, 32'(ram_we), 0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 0);
        chk({tag, " ram_din"}, 32'(ram_din), 0);
        chk({tag, " ram_ublb"}, 32'({ram_ub, ram_lb}), 0);
    endtask

    task automatic cpu_xfer(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic ub,
                            input logic lb, output int lat);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_din = d;
        cpu_ub = ub;
        cpu_lb = lb;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = c;
                break;
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic vid_xfer(input logic [AW-1:0] a, output int lat);
        vid_req = 1'b1;
        vid_addr = a;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (vid_ack) begin
                lat = c;
                break;
            end
        end
        vid_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int vc;
        int cc;
        int vcnt;
        int ccnt;
        int first_c;
        reset = 1'b1;
        preload = 1'b1;
        vid_req = 1'b0;
        vid_addr = '0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_din = '0;
        cpu_ub = 1'b0;
        cpu_lb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk_zero_outs("reset");
        chk("reset vid_dout", 32'(vid_dout), 0);
        chk("reset cpu_dout", 32'(cpu_dout), 0);
        reset = 1'b0;
        @(negedge clk);

        // CPU write with in-flight RAM checks
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h0123;
        cpu_din = 16'hBEEF;
        cpu_ub = 1'b1;
        cpu_lb = 1'b1;
        @(negedge clk);
        chk("wr access ram_we", 32'(ram_we), 1);
        chk("wr access ram_addr", 32'(ram_addr), 32'h0123);
        chk("wr access ram_din", 32'(ram_din), 32'hBEEF);
        chk("wr access ublb", 32'({ram_ub, ram_lb}), 3);
        @(negedge clk);
        chk("wr data ram_we", 32'(ram_we), 0);
        chk("wr data no ack", 32'(cpu_ack), 0);
        @(negedge clk);
        chk("wr ack at N+3", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("wr ack pulse", 32'(cpu_ack), 0);

        cpu_xfer(1'b0, 14'h0123, 16'h0000, 1'b1, 1'b1, lat);
        chk("rd lat", 32'(lat), 3);
        chk("rd 0x123", 32'(cpu_dout), 32'hBEEF);

        // Byte lanes
        cpu_xfer(1'b1, 14'h0005, 16'h1234, 1'b1, 1'b1, lat);
        chk("wr5 lat", 32'(lat), 3);
        chk("wr keeps cpu_dout", 32'(cpu_dout), 32'hBEEF);
        cpu_xfer(1'b1, 14'h0005, 16'hAA55, 1'b1, 1'b0, lat);
        cpu_xfer(1'b0, 14'h0005, 16'h0000, 1'b1, 1'b1, lat);
        chk("byte lane ub", 32'(cpu_dout), 32'hAA34);
        cpu_xfer(1'b1, 14'h0005, 16'hFFFF, 1'b0, 1'b0, lat);
        chk("no-lane wr acks", 32'(lat), 3);
        cpu_xfer(1'b0, 14'h0005, 16'h0000, 1'b1, 1'b1, lat);
        chk("no-lane wr no change", 32'(cpu_dout), 32'hAA34);

        // Lone video read; leaves last grant on video
        vid_xfer(14'h0030, lat);
        chk("vid lat", 32'(lat), 3);
        chk("vid dout", 32'(vid_dout), 32'h5A30);
        chk("vid keeps cpu_dout", 32'(cpu_dout), 32'hAA34);

        // Collision
        vid_req = 1'b1;
        vid_addr = 14'h0010;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 14'h0020;
        vc = 0;
        cc = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (vid_ack) begin
                vc = c;
                vid_req = 1'b0;
            end
            if (cpu_ack) begin
                cc = c;
                cpu_req = 1'b0;
            end
            if (vc != 0 && cc != 0) break;
        end
`ifdef RAM_ARB_RR_EN
        chk("coll rr cpu ack", 32'(cc), 3);
        chk("coll rr vid ack", 32'(vc), 6);
`else
        chk("coll vid ack", 32'(vc), 3);
        chk("coll cpu ack", 32'(cc), 6);
`endif
        chk("coll vid dout", 32'(vid_dout), 32'h5A10);
        chk("coll cpu dout", 32'(cpu_dout), 32'h5A20);
        @(negedge clk);

        // Starvation: video held for 20 accesses
        vid_req = 1'b1;
        vid_addr = 14'h0011;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 14'h0021;
        vcnt = 0;
        ccnt = 0;
        first_c = 0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ccnt++;
                if (first_c == 0) first_c = c;
            end
            if (vid_ack) vcnt++;
            if (vcnt == 20) break;
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        chk("starve vid count", 32'(vcnt), 20);
`ifdef RAM_ARB_RR_EN
        chk("rr cpu served <=6", 32'(first_c >= 1 && first_c <= 6), 1);
`else
        chk("starve cpu acks", 32'(ccnt), 0);
`endif
        repeat (4) @(negedge clk);

        // Reset during the ACCESS cycle of a write
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h0040;
        cpu_din = 16'h1111;
        cpu_ub = 1'b1;
        cpu_lb = 1'b1;
        @(negedge clk);
        chk("rst pre ram_we", 32'(ram_we), 1);
        #1 reset = 1'b1;
        #1 chk_zero_outs("rst async");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst no ack", 32'({vid_ack, cpu_ack}), 0);
        end
        cpu_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_zero_outs("rst idle");
        chk("rst write aborted", 32'(mem[14'h0040]), 32'h5A40);
        cpu_xfer(1'b0, 14'h0040, 16'h0000, 1'b1, 1'b1, lat);
        chk("post-rst lat", 32'(lat), 3);
        chk("post-rst rd", 32'(cpu_dout), 32'h5A40);

        // Inputs change after grant
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h0050;
        cpu_din = 16'h7777;
        @(negedge clk);
        cpu_addr = 14'h0051;
        cpu_din = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("late chg ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("late chg mem50", 32'(mem[14'h0050]), 32'h7777);
        chk("late chg mem51", 32'(mem[14'h0051]), 32'h5A51);
        cpu_xfer(1'b0, 14'h0050, 16'h0000, 1'b1, 1'b1, lat);
        chk("late chg rd", 32'(cpu_dout), 32'h7777);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
